// File: rtl/irq_controller.sv
// Four-source edge-detecting interrupt controller with IE/PEND/POL/RAW registers in the IO window.
// Define IRQ_SYNC_EN to add a two-flop synchroniser per source (asynchronous src_in).
module irq_controller #(
    parameter logic [15:0] BASE_ADDR = 16'h1020,
    parameter int          NUM_SRC   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [15:0]        io_addr,
    input  logic [7:0]         io_wdata,
    input  logic               io_we,
    input  logic               io_re,
    output logic [7:0]         io_rdata,
    output logic [NUM_SRC-1:0] irq_out,
    input  logic [NUM_SRC-1:0] irq_clr
);
    localparam logic [1:0] OFF_IE   = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_POL  = 2'd2;
    localparam logic [1:0] OFF_RAW  = 2'd3;

    logic [NUM_SRC-1:0] r_ie;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_pol;
    logic [NUM_SRC-1:0] r_irq;
    logic [7:0]         r_rdata;
    logic [NUM_SRC-1:0] r_prev;

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_raw;
    logic [NUM_SRC-1:0] w_evt;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_rmux;
    logic [15:0]        w_off;
    logic [1:0]         w_sel;
    logic               w_hit;
    logic               w_wr;
    logic               w_rd;
    logic               w_unused;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync_p0;
    logic [NUM_SRC-1:0] r_sync_p1;

    // Synchroniser stage boundary: src_in -> p0 -> p1 (never reset, keeps tracking)
    always_ff @(posedge clk) begin
        r_sync_p0 <= src_in;
        r_sync_p1 <= r_sync_p0;
    end

    assign w_s   = r_sync_p1;
    assign w_raw = r_sync_p1;
`else
    assign w_s   = src_in;
    assign w_raw = r_prev;
`endif

    // Previous-sample flop is unreset so a level held across reset is not seen as an edge
    always_ff @(posedge clk) begin
        r_prev <= w_s;
    end

    assign w_evt = (r_pol & r_prev & ~w_s) | (~r_pol & w_s & ~r_prev);

    assign w_off    = io_addr - BASE_ADDR;
    assign w_sel    = w_off[1:0];
    assign w_hit    = (w_off[15:2] == 14'd0);
    assign w_wr     = io_we & w_hit;
    assign w_rd     = io_re & w_hit;
    assign w_w1c    = (w_wr && (w_sel == OFF_PEND)) ? io_wdata[NUM_SRC-1:0] : '0;
    assign w_unused = ^io_wdata[7:NUM_SRC];

    always_comb begin
        w_rmux = '0;
        case (w_sel)
            OFF_IE:   w_rmux = r_ie;
            OFF_PEND: w_rmux = r_pend;
            OFF_POL:  w_rmux = r_pol;
            OFF_RAW:  w_rmux = w_raw;
            default:  w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ie    <= '0;
            r_pend  <= '0;
            r_pol   <= '0;
            r_irq   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr && (w_sel == OFF_IE))
                r_ie <= io_wdata[NUM_SRC-1:0];
            if (w_wr && (w_sel == OFF_POL))
                r_pol <= io_wdata[NUM_SRC-1:0];
            // A new event always wins over a same-cycle acknowledge or W1C
            r_pend <= w_evt | (r_pend & ~irq_clr & ~w_w1c);
            r_irq  <= r_pend & r_ie;
            if (w_rd)
                r_rdata <= {{(8-NUM_SRC){1'b0}}, w_rmux};
        end
    end

    assign io_rdata = r_rdata;
    assign irq_out  = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic against a sample-history model.
// Build with or without IRQ_SYNC_EN to match the RTL configuration.
module tb_irq_controller;
    localparam logic [15:0] BASE = 16'h1020;
`ifdef IRQ_SYNC_EN
    localparam int SL  = 2;
    localparam int RL  = 2;
    localparam int LAT = 3;
`else
    localparam int SL  = 0;
    localparam int RL  = 1;
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_in;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_re;
    logic [7:0]  io_rdata;
    logic [3:0]  irq_out;
    logic [3:0]  irq_clr;

    int total = 0;
    int bad   = 0;

    // Reference model: src_in history sampled at each clock, plus architectural registers
    logic [3:0] hist [0:3];
    logic [3:0] m_ie, m_pend, m_pol, m_irq;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(4)) dut (
        .clk(clk), .reset(reset), .src_in(src_in), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
        .irq_out(irq_out), .irq_clr(irq_clr)
    );

    task automatic model_edge();
        logic [3:0]  s, p, evt, w1c, o_ie, o_pend, o_pol;
        logic [15:0] off;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = src_in;
        s   = hist[SL];
        p   = hist[SL+1];
        evt = m_pol ? 4'h0 : 4'h0;
        for (int i = 0; i < 4; i++)
            evt[i] = m_pol[i] ? (p[i] && !s[i]) : (s[i] && !p[i]);
        off = io_addr - BASE;
        if (!reset) begin
            m_ie = 0; m_pend = 0; m_pol = 0; m_irq = 0; m_rdata = 0;
        end else begin
            o_ie = m_ie; o_pend = m_pend; o_pol = m_pol;
            if (io_re && off < 4) begin
                case (off)
                    0: m_rdata = {4'h0, o_ie};
                    1: m_rdata = {4'h0, o_pend};
                    2: m_rdata = {4'h0, o_pol};
                    default: m_rdata = {4'h0, hist[RL]};
                endcase
            end
            m_irq = o_pend & o_ie;
            w1c = 4'h0;
            if (io_we && off < 4) begin
                case (off)
                    0: m_ie = io_wdata[3:0];
                    1: w1c = io_wdata[3:0];
                    2: m_pol = io_wdata[3:0];
                    default: ;
                endcase
            end
            m_pend = evt | (o_pend & ~irq_clr & ~w1c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        tick();
        io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        io_addr = a; io_re = 1'b1;
        tick();
        io_re = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL reset1_irq: got %h want 0", irq_out); end
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL reset1_rdata: got %h want 00", io_rdata); end
        reset = 1'b1;
        bus_write(BASE, 8'h0F);
        bus_write(BASE + 16'd2, 8'h0F);
        src_in = 4'h0;
        repeat (LAT + 2) tick();
        total++; if (irq_out !== 4'hF) begin bad++; $display("FAIL pre_reset_irq: got %h want F", irq_out); end
        bus_read(BASE + 16'd1);
        src_in = 4'hF;
        repeat (LAT + 2) tick();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL reset2_irq: got %h want 0", irq_out); end
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL reset2_rdata: got %h want 00", io_rdata); end
        reset = 1'b1;
        repeat (LAT + 2) tick();
        bus_read(BASE);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL reset_ie: got %h want 00", io_rdata); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL reset_pend: got %h want 00", io_rdata); end
        bus_read(BASE + 16'd2);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL reset_pol: got %h want 00", io_rdata); end
    endtask

    task automatic test_rising();
        src_in = 4'h0;
        repeat (LAT + 2) tick();
        bus_write(BASE, 8'h01);
        src_in[0] = 1'b1;
        repeat (LAT) tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL rise_irq_early: got %h want 0", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h01) begin bad++; $display("FAIL rise_pend: got %h want 01", io_rdata); end
        total++; if (irq_out !== 4'h1) begin bad++; $display("FAIL rise_irq: got %h want 1", irq_out); end
        irq_clr = 4'h1;
        tick();
        irq_clr = 4'h0;
        tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL rise_clr_irq: got %h want 0", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL rise_clr_pend: got %h want 00", io_rdata); end
    endtask

    task automatic test_polarity();
        bus_write(BASE + 16'd2, 8'h02);
        bus_write(BASE, 8'h02);
        src_in[1] = 1'b1;
        repeat (LAT + 2) tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL pol_rise_irq: got %h want 0", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL pol_rise_pend: got %h want 00", io_rdata); end
        src_in[1] = 1'b0;
        repeat (LAT + 1) tick();
        total++; if (irq_out !== 4'h2) begin bad++; $display("FAIL pol_fall_irq: got %h want 2", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h02) begin bad++; $display("FAIL pol_fall_pend: got %h want 02", io_rdata); end
        bus_write(BASE + 16'd1, 8'h02);
        tick();
        bus_write(BASE + 16'd2, 8'h00);
        repeat (2) tick();
        bus_write(BASE + 16'd2, 8'h02);
        repeat (2) tick();
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL pol_toggle_pend: got %h want 00", io_rdata); end
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL pol_toggle_irq: got %h want 0", irq_out); end
    endtask

    task automatic test_masked();
        bus_write(BASE, 8'h00);
        bus_write(BASE + 16'd2, 8'h00);
        src_in[2] = 1'b1;
        repeat (LAT + 2) tick();
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h04) begin bad++; $display("FAIL mask_pend: got %h want 04", io_rdata); end
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL mask_irq: got %h want 0", irq_out); end
        bus_write(BASE, 8'h04);
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL mask_ie_same: got %h want 0", irq_out); end
        tick();
        total++; if (irq_out !== 4'h4) begin bad++; $display("FAIL mask_ie_irq: got %h want 4", irq_out); end
        bus_write(BASE + 16'd1, 8'h04);
        tick();
        total++; if (irq_out !== 4'h0) begin bad++; $display("FAIL mask_w1c_irq: got %h want 0", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL mask_w1c_pend: got %h want 00", io_rdata); end
    endtask

    task automatic test_collision();
        bus_write(BASE, 8'h08);
        src_in[3] = 1'b1;
        repeat (LAT + 1) tick();
        total++; if (irq_out !== 4'h8) begin bad++; $display("FAIL coll_first_irq: got %h want 8", irq_out); end
        src_in[3] = 1'b0;
        repeat (LAT + 2) tick();
        src_in[3] = 1'b1;
        repeat (LAT - 1) tick();
        irq_clr = 4'h8;
        tick();
        irq_clr = 4'h0;
        tick();
        total++; if (irq_out !== 4'h8) begin bad++; $display("FAIL coll_irq: got %h want 8", irq_out); end
        bus_read(BASE + 16'd1);
        total++; if (io_rdata !== 8'h08) begin bad++; $display("FAIL coll_pend: got %h want 08", io_rdata); end
        total++; if (irq_out !== 4'h8) begin bad++; $display("FAIL coll_irq_hold: got %h want 8", irq_out); end
    endtask

    task automatic test_bus();
        src_in = 4'hA;
        repeat (3) tick();
        bus_read(BASE + 16'd3);
        total++; if (io_rdata !== 8'h0A) begin bad++; $display("FAIL bus_raw: got %h want 0A", io_rdata); end
        bus_read(BASE + 16'd4);
        total++; if (io_rdata !== 8'h0A) begin bad++; $display("FAIL bus_oor_read: got %h want 0A", io_rdata); end
        bus_write(BASE, 8'hFF);
        bus_read(BASE);
        total++; if (io_rdata !== 8'h0F) begin bad++; $display("FAIL bus_ie_rb: got %h want 0F", io_rdata); end
        io_addr = BASE + 16'd2; io_wdata = 8'h05; io_we = 1'b1; io_re = 1'b1;
        tick();
        io_we = 1'b0; io_re = 1'b0;
        total++; if (io_rdata !== 8'h00) begin bad++; $display("FAIL bus_rw_old: got %h want 00", io_rdata); end
        bus_read(BASE + 16'd2);
        total++; if (io_rdata !== 8'h05) begin bad++; $display("FAIL bus_rw_new: got %h want 05", io_rdata); end
        bus_write(BASE + 16'd3, 8'h00);
        bus_write(BASE - 16'd1, 8'h00);
        bus_read(BASE);
        total++; if (io_rdata !== 8'h0F) begin bad++; $display("FAIL bus_ignored_wr: got %h want 0F", io_rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) src_in = 4'($urandom);
            reset    = ($urandom_range(79) != 0);
            io_we    = ($urandom_range(2) == 0);
            io_re    = ($urandom_range(1) == 0);
            io_addr  = BASE - 16'd2 + 16'($urandom_range(7));
            io_wdata = 8'($urandom);
            irq_clr  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            tick();
            total++; if (irq_out !== m_irq) begin bad++; $display("FAIL rnd_irq[%0d]: got %h want %h", n, irq_out, m_irq); end
            total++; if (io_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, io_rdata, m_rdata); end
        end
        reset = 1'b1; io_we = 1'b0; io_re = 1'b0; irq_clr = 4'h0;
        tick();
    endtask

    initial begin
        reset = 1'b0; src_in = 4'hF; io_addr = 16'h0000; io_wdata = 8'h00;
        io_we = 1'b0; io_re = 1'b0; irq_clr = 4'h0;
        for (int k = 0; k < 4; k++) hist[k] = 4'hF;
        m_ie = 0; m_pend = 0; m_pol = 0; m_irq = 0; m_rdata = 0;
        test_reset();
        test_rising();
        test_polarity();
        test_masked();
        test_collision();
        test_bus();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
